// File: rtl/spi_rom_pkg.sv
// Shared constants and FSM state type for the SPI ROM burst reader.
package spi_rom_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int         SPI_ADDR_LEN = 24;
    localparam int         SPI_CMD_LEN  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/spi_rom_fetcher_rx_capture.sv
// MISO capture buffer. This is the only logic clocked on the falling clk edge,
// i.e. the rising spi_sclk edge, where the ROM's output bit is stable.
module spi_rx_capture #(
    parameter int DATA_BITS = 128,
    parameter int IDX_W     = $clog2(DATA_BITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cap_en,
    input  logic [IDX_W-1:0] cap_idx,
    input  logic             spi_miso,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_data
);

    logic [DATA_BITS-1:0] buf_q;
    logic [DATA_BITS-1:0] buf_d;

    // Write the current MISO bit into its slot while the FSM is in DATA.
    always_comb begin
        buf_d = buf_q;
        if (cap_en) begin
            buf_d[cap_idx] = spi_miso;
        end
    end

    // Capture mid-bit on the falling clk edge; reset clears the whole buffer.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign rd_data = buf_q[rd_index];

endmodule

// File: rtl/spi_rom_fetcher.sv
// Autonomous SPI flash burst reader: sends READ + 24-bit address, then
// captures DATA_BITS MISO bits into a randomly readable bit buffer.
module spi_rom_fetcher
    import spi_rom_pkg::*;
#(
    parameter int         DATA_BITS = 128,
    parameter logic [7:0] CMD       = SPI_CMD_READ,
    parameter int         IDX_W     = $clog2(DATA_BITS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [23:0]      addr,
    output logic             busy,
    output logic             done,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_data,
    output logic             spi_cs,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int CNT_W = $clog2((DATA_BITS > SPI_ADDR_LEN) ? DATA_BITS : SPI_ADDR_LEN);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(SPI_CMD_LEN - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(SPI_ADDR_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state and next-output logic; outputs are derived from the next
    // state so the registered pins line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                    addr_d  = addr;
                end
            end
            ST_CMD: begin
                if (cnt_q == CMD_LAST) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        cs_d   = (state_d != ST_IDLE);
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_CMD:  mosi_d = CMD[3'(SPI_CMD_LEN - 1) - cnt_d[2:0]];
            ST_ADDR: mosi_d = addr_d[5'(SPI_ADDR_LEN - 1) - cnt_d[4:0]];
            default: mosi_d = 1'b0;
        endcase
    end

    // Sequencer state, bit counter, latched address and registered pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            cs_q    <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    spi_rx_capture #(
        .DATA_BITS (DATA_BITS),
        .IDX_W     (IDX_W)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .cap_en   (state_q == ST_DATA),
        .cap_idx  (IDX_W'(cnt_q)),
        .spi_miso (spi_miso),
        .rd_index (rd_index),
        .rd_data  (rd_data)
    );

    assign spi_sclk = ~clk;
    assign spi_cs   = cs_q;
    assign spi_mosi = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_spi_rom_fetcher.sv
`timescale 1ns/1ps
module tb_spi_rom_fetcher;

    localparam int DB = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [23:0]   addr = '0;
    logic          busy, done, rd_data, spi_cs, spi_sclk, spi_mosi;
    logic          spi_miso = 1'b0;
    logic [6:0]    rd_index = '0;

    spi_rom_fetcher #(.DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr),
        .busy(busy), .done(done), .rd_index(rd_index), .rd_data(rd_data),
        .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ROM content model
    int rom_mode = 0;   // 0 = table/pattern, 1 = all ones, 2 = all zeros

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        if (rom_mode == 1) return 8'hFF;
        if (rom_mode == 2) return 8'h00;
        case (a)
            24'h000A50: return 8'hA5;
            24'h000A51: return 8'h3C;
            default:    return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic rom_bit(input logic [23:0] a, input int j);
        logic [7:0] b;
        b = rom_byte(a + 24'(j / 8));
        return b[7 - (j % 8)];
    endfunction

    function automatic logic [DB-1:0] rom_vec(input logic [23:0] a);
        logic [DB-1:0] v;
        for (int j = 0; j < DB; j++) v[j] = rom_bit(a, j);
        return v;
    endfunction

    // SPI ROM pin model: samples MOSI on rising sclk, shifts MISO on falling sclk
    int          rx_cnt = 0;
    logic [31:0] rx_sh = '0;
    logic [23:0] rom_addr = '0;
    logic [23:0] rom_log[$];
    logic [7:0]  cmd_log[$];

    always @(negedge clk) begin
        if (spi_cs) begin
            if (rx_cnt < 32) begin
                rx_sh = {rx_sh[30:0], spi_mosi};
                if (rx_cnt == 31) begin
                    rom_addr = rx_sh[23:0];
                    rom_log.push_back(rx_sh[23:0]);
                    cmd_log.push_back(rx_sh[31:24]);
                end
            end
            rx_cnt++;
        end
    end

    always @(posedge clk) begin
        #2;
        if (!spi_cs) begin
            rx_cnt   = 0;
            spi_miso = 1'b0;
        end else if (rx_cnt >= 32 && rx_cnt < 32 + DB) begin
            spi_miso = rom_bit(rom_addr, rx_cnt - 32);
        end else begin
            spi_miso = 1'b0;
        end
    end

    task automatic read_buf(output logic [DB-1:0] v);
        for (int i = 0; i < DB; i++) begin
            rd_index = 7'(i);
            #0.02;
            v[i] = rd_data;
        end
    endtask

    // Scoreboard
    typedef struct {
        int            n;
        logic [23:0]   a;
        logic [DB-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int            cs_rise = -1;
    int            cs_len  = 0;
    logic          cs_prev = 1'b0;
    exp_t          me;
    logic [DB-1:0] mv;

    always @(negedge clk) begin
        if (reset) begin
            cs_prev = 1'b0;
            cs_len  = 0;
        end else begin
            if (spi_cs && !cs_prev) begin
                cs_rise = cyc;
                cs_len  = 0;
            end
            if (spi_cs) cs_len++;
            cs_prev = spi_cs;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk_bit("unexpected_done", 1'b1, 1'b0);
                end else begin
                    me = exp_q.pop_front();
                    chk_int("done_cycle", cyc, me.n + 33 + DB);
                    chk_int("cs_rise_cycle", cs_rise, me.n + 1);
                    chk_int("cs_len", cs_len, 32 + DB);
                    chk_bit("cs_low_at_done", spi_cs, 1'b0);
                    chk_bit("busy_low_at_done", busy, 1'b0);
                    if (rom_log.size() == 0) begin
                        chk_bit("rom_txn_missing", 1'b1, 1'b0);
                    end else begin
                        chk_int("rom_addr", int'(rom_log.pop_front()), int'(me.a));
                        chk_int("rom_cmd", int'(cmd_log.pop_front()), 32'h03);
                    end
                    read_buf(mv);
                    chk_vec("buffer", mv, me.data);
                end
            end
        end
    end

    // Stimulus helpers
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic issue(input int n, input logic [23:0] a, input bit expect_it);
        exp_t e;
        wait_until(n);
        start = 1'b1;
        addr  = a;
        if (expect_it) begin
            e.n = n; e.a = a; e.data = rom_vec(a);
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk_bit("done_timeout", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int            t0;
        logic [31:0]   mosi_v;
        logic [DB-1:0] v;
        logic [DB-1:0] ev;

        // Reset state
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_bit("rst_cs", spi_cs, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_mosi", spi_mosi, 1'b0);
        read_buf(v);
        chk_vec("rst_buffer", v, '0);
        @(negedge clk);
        reset = 1'b0;

        // Fetch timing, MOSI framing, data capture, start while busy
        t0 = cyc;
        rom_mode = 0;
        issue(t0 + 10, 24'h000A50, 1'b1);
        chk_bit("busy_after_start", busy, 1'b1);
        chk_bit("cs_after_start", spi_cs, 1'b1);
        mosi_v = '0;
        for (int i = 0; i < 32; i++) begin
            mosi_v = {mosi_v[30:0], spi_mosi};
            @(negedge clk);
        end
        chk_int("mosi_frame", int'(mosi_v), 32'h03000A50);
        issue(t0 + 50, 24'hFFFFFF, 1'b0);
        wait_done(200);
        @(posedge clk);
        #1;
        chk_bit("done_one_cycle", done, 1'b0);
        read_buf(v);
        chk_int("first16_bits", int'(v[15:0]), 32'h3CA5);
        chk_int("single_rom_txn", rom_log.size(), 0);

        // Back-to-back with start held high
        t0 = cyc;
        wait_until(t0 + 10);
        start = 1'b1;
        addr  = 24'h000100;
        me.n = t0 + 10;  me.a = 24'h000100; me.data = rom_vec(24'h000100);
        exp_q.push_back(me);
        me.n = t0 + 11 + 32 + DB;
        exp_q.push_back(me);
        wait_until(t0 + 12 + 32 + DB);
        start = 1'b0;
        wait_until(t0 + 2 * (33 + DB) + 15);
        chk_int("b2b_all_done", exp_q.size(), 0);
        chk_bit("b2b_idle", busy, 1'b0);

        // Reset in the middle of DATA (bit 50)
        t0 = cyc;
        issue(t0 + 10, 24'h000200, 1'b1);
        wait_until(t0 + 10 + 33 + 50);
        #1 reset = 1'b1;
        exp_q.delete();
        rom_log.delete();
        cmd_log.delete();
        #1;
        chk_bit("midrst_cs", spi_cs, 1'b0);
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_done", done, 1'b0);
        chk_bit("midrst_mosi", spi_mosi, 1'b0);
        read_buf(v);
        chk_vec("midrst_buffer", v, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_bit("no_resume_after_reset", spi_cs, 1'b0);
        t0 = cyc;
        issue(t0 + 10, 24'h000300, 1'b1);
        wait_done(200);

        // Buffer retention: all ones, then all zeros sampled mid-fetch
        t0 = cyc;
        rom_mode = 1;
        issue(t0 + 10, 24'h000400, 1'b1);
        wait_done(200);
        t0 = cyc;
        rom_mode = 2;
        issue(t0 + 10, 24'h000500, 1'b1);
        wait_until(t0 + 10 + 33 + 39);
        @(posedge clk);
        #1;
        read_buf(v);
        ev = {{(DB-40){1'b1}}, {40{1'b0}}};
        chk_vec("retain_at_bit40", v, ev);
        @(posedge clk);
        #1;
        read_buf(v);
        ev = {{(DB-41){1'b1}}, {41{1'b0}}};
        chk_vec("retain_after_bit40", v, ev);
        wait_done(200);
        repeat (4) @(negedge clk);
        chk_int("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
